simple_wire: RTL and testbench
==============================

Name: simple_wire

Overview:
- Single-bit pass-through "wire": `out` follows `in` combinationally, with zero latency.
- Adds a small clocked observation stage alongside the wire: registered copy, edge pulses, a saturating toggle counter and a stability flag.
- Used as the simplest connectivity block in example designs and as a probe point for board-level signal checks.
- The combinational path is independent of clock and reset.

Parameters:
- CNT_W, 8: width of the toggle counter; range 1..32.
- STABLE_CYCLES, 4: consecutive unchanged samples required before `stable` asserts; range 1..255.

Ports:
- clk  input  1  system clock, rising-edge active; default bench period 100 ns.
- rstn  input  1  asynchronous active-low reset; all registers clear immediately on assertion; release is synchronous to clk.
- in  input  1  wire input.
- clr  input  1  synchronous clear of toggle_cnt.
- out  output  1  combinational copy of in.
- out_q  output  1  in sampled on each clk rising edge.
- rise  output  1  one-cycle pulse on a sampled 0->1 change.
- fall  output  1  one-cycle pulse on a sampled 1->0 change.
- toggle_cnt  output  CNT_W  saturating count of sampled edges.
- stable  output  1  high once in has stayed unchanged for STABLE_CYCLES samples.

Behaviour:
- out = in at all times, including during reset and with clk stopped. No register and no gating on this path.
- Reset (rstn=0), asynchronous: out_q=0, rise=0, fall=0, toggle_cnt=0, stable=0, internal stability counter=0.
- Each rising clk edge with rstn=1, let chg = (in != out_q), evaluated with pre-edge values:
  - out_q <= in.
  - rise <= in & ~out_q; fall <= ~in & out_q. Each is high for exactly one cycle per sampled change.
  - toggle_cnt:
    - clr=1: toggle_cnt <= 0. clr wins over a simultaneous edge.
    - else if chg and toggle_cnt < 2^CNT_W-1: toggle_cnt <= toggle_cnt+1.
    - else: hold. Saturates at all-ones, no wrap.
  - Stability counter sc (0..STABLE_CYCLES):
    - chg: sc <= 0.
    - else if sc < STABLE_CYCLES: sc <= sc+1.
    - Saturates at STABLE_CYCLES.
  - stable = (sc == STABLE_CYCLES), decoded from the register with no extra latency.
- First edge after reset release:
  - out_q was 0, so in=1 counts as a change: rise=1, toggle_cnt=1.
  - in=0 counts as no change: sc increments.
- Reset asserted mid-operation clears all registers immediately, including any pulse in flight. out keeps following in.
- Pulses narrower than one clk period may be missed by the clocked outputs; only out reflects them.
- Latency: out 0 cycles; out_q, rise and fall 1 edge; toggle_cnt 1 edge; stable at the edge where sc reaches STABLE_CYCLES.
- No X propagation from unused logic. All outputs are defined once rstn has been asserted.

Test Plan:
- rstn=0, in=0, then release; hold in=0 for 10 cycles -> out=0, out_q=0, rise=fall=0, toggle_cnt=0; stable=1 from the 4th edge after release.
- in 0->1 at t=1 us with clk running -> out=1 within the same timestep; at the next edge out_q=1, rise=1 for one cycle, toggle_cnt=1, stable=0; stable=1 again 4 edges later.
- Toggle in every cycle for 300 cycles with CNT_W=8 -> toggle_cnt stops at 255; rise/fall alternate each cycle; stable stays 0.
- clr=1 on the same edge as an in change (toggle_cnt=5) -> toggle_cnt=0 afterwards; rise/fall still pulse.
- Assert rstn=0 mid-stream with in=1, out_q=1, toggle_cnt=7 -> all registered outputs 0 immediately, out stays 1. After release, the first edge gives rise=1 and toggle_cnt=1.
- Stop clk, toggle in 0->1->0 -> out tracks each change; registered outputs unchanged.

Source files
------------

// File: rtl/simple_wire.sv
// Single-bit pass-through wire with a clocked observation stage: registered copy,
// edge pulses, saturating toggle counter and a stability flag.
module simple_wire #(
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    input  logic             clr,
    output logic             out,
    output logic             out_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             stable
);

    localparam int              SC_W   = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

    logic [SC_W-1:0] sc;
    logic            chg;

    // The wire itself: no clock, no reset, no gating.
    assign out = in;

    assign chg    = in ^ out_q;
    assign stable = (sc == SC_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle_cnt <= '0;
            sc         <= '0;
        end else begin
            out_q <= in;
            rise  <= in & ~out_q;
            fall  <= ~in & out_q;

            // clr has priority over a simultaneous edge; the count sticks at all-ones.
            if (clr) begin
                toggle_cnt <= '0;
            end else if (chg && (toggle_cnt != '1)) begin
                toggle_cnt <= toggle_cnt + 1'b1;
            end

            if (chg) begin
                sc <= '0;
            end else if (sc != SC_MAX) begin
                sc <= sc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simple_wire.sv
// Directed plus randomized bench for simple_wire, checked against a behavioural
// model that tracks the last sample, the number of edges seen and the current run length.
module tb_simple_wire;

    localparam int CNT_W         = 8;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             in;
    logic             clr;
    logic             out;
    logic             out_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] toggle_cnt;
    logic             stable;

    logic run_clk;
    int   total;
    int   bad;

    // Reference model state.
    bit m_q;
    bit m_rise;
    bit m_fall;
    int m_edges;
    int m_run;

    simple_wire #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in),
        .clr        (clr),
        .out        (out),
        .out_q      (out_q),
        .rise       (rise),
        .fall       (fall),
        .toggle_cnt (toggle_cnt),
        .stable     (stable)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #50;
            if (run_clk) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q     = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_edges = 0;
        m_run   = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},        32'(out),        32'(in));
        chk({tag, ".out_q"},      32'(out_q),      32'(m_q));
        chk({tag, ".rise"},       32'(rise),       32'(m_rise));
        chk({tag, ".fall"},       32'(fall),       32'(m_fall));
        chk({tag, ".toggle_cnt"}, 32'(toggle_cnt), 32'(m_edges));
        chk({tag, ".stable"},     32'(stable),     32'(m_run >= STABLE_CYCLES));
    endtask

    // One clock edge: update the model from the pre-edge inputs, then check just after.
    task automatic step(input string tag);
        bit changed;
        @(posedge clk);
        changed = (in != m_q);
        m_rise  = changed && in;
        m_fall  = changed && !in;
        if (clr) m_edges = 0;
        else if (changed) m_edges = (m_edges + 1 > CNT_MAX) ? CNT_MAX : m_edges + 1;
        m_run = changed ? 0 : ((m_run + 1 > STABLE_CYCLES) ? STABLE_CYCLES : m_run + 1);
        m_q   = in;
        #1;
        check_all(tag);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        run_clk = 1'b1;
        rstn    = 1'b0;
        in      = 1'b0;
        clr     = 1'b0;
        model_reset();

        // Reset state, then hold in=0 across the release.
        #10;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("idle_low");
            if (i == 2) chk("idle_low.edge3_not_stable", 32'(stable), 32'd0);
            if (i == 3) chk("idle_low.edge4_stable", 32'(stable), 32'd1);
        end

        // Rising input: out follows immediately, clocked outputs at the next edge.
        in = 1'b1;
        #1;
        chk("rise_now.out", 32'(out), 32'd1);
        step("rise_edge");
        chk("rise_edge.rise_pulse", 32'(rise), 32'd1);
        for (int i = 0; i < 5; i++) step("rise_hold");

        // Toggle every cycle well past saturation.
        for (int i = 0; i < 300; i++) begin
            #5 in = ~in;
            step("toggle");
        end
        chk("toggle.saturated", 32'(toggle_cnt), 32'(CNT_MAX));

        // Clear coinciding with an edge.
        #5 clr = 1'b1;
        step("clr_first");
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #5 in = ~in;
            step("clr_build");
        end
        chk("clr_build.cnt5", 32'(toggle_cnt), 32'd5);
        #5 in = ~in;
        clr = 1'b1;
        step("clr_with_edge");
        chk("clr_with_edge.cnt0", 32'(toggle_cnt), 32'd0);
        clr = 1'b0;

        // Build in=1, out_q=1, toggle_cnt=7, then reset asynchronously mid-cycle.
        #5 in = 1'b0;
        clr = 1'b1;
        step("prep_clr");
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #5 in = ~in;
            step("prep_build");
        end
        chk("prep.cnt7", 32'(toggle_cnt), 32'd7);
        chk("prep.out_q1", 32'(out_q), 32'd1);
        #20 rstn = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #20 rstn = 1'b1;
        step("post_reset");
        chk("post_reset.rise", 32'(rise), 32'd1);
        chk("post_reset.cnt1", 32'(toggle_cnt), 32'd1);

        // Stopped clock: only out tracks the input.
        #5 run_clk = 1'b0;
        #200;
        for (int i = 0; i < 4; i++) begin
            in = ~in;
            #30;
            check_all("clk_stopped");
        end
        run_clk = 1'b1;

        // Randomized traffic with occasional clears and asynchronous resets.
        for (int i = 0; i < 250; i++) begin
            #($urandom_range(2, 40));
            in  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 40) == 0) begin
                rstn = 1'b0;
                #1;
                model_reset();
                check_all("rand_reset");
                rstn = 1'b1;
            end
            step("random");
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
